// File: rtl/sys_ctrl_burst.sv
// -----------------------------------------------------------------------------
// sys_ctrl_burst
//
// REF_CLK-domain system controller. It decodes command frames that arrive as
// synchronised UART RX bytes, drives the register file (single and burst
// access with address auto-increment) and the ALU, and pushes response bytes
// into the TX async FIFO. The FIFO-full flag applies backpressure. A stalled
// frame is dropped after TIMEOUT idle cycles and reported on cmd_err.
//
// Frames (the address byte uses its low ADDR_WIDTH bits):
//   AA addr data         RF write
//   BB addr              RF read, one byte returned
//   CC A B fun           A -> RF[0], B -> RF[1], then ALU run
//   DD fun               ALU run on the current operands
//   EE addr N d0..dN-1   burst write
//   EF addr N            burst read, N bytes returned
//
// Ports:
//   CLK, RST        clock, asynchronous active-low reset
//   RX_P_DATA       synchronised RX byte, qualified by the RX_ENABLE strobe
//   FIFO_FULL       TX FIFO full; a response byte is held while it is high
//   Rd_Data         RF read data, qualified by Rd_Data_Valid
//   ALU_OUT         ALU result, qualified by ALU_Valid
//   Wr_En, Rd_En    RF strobes; Address and Wr_Data qualify them
//   ALU_EN, ALU_FUN ALU start strobe and function
//   CLK_EN          ALU clock-gate enable, held from start to result
//   clk_div_en      UART clock-divider enable, high from the first clock
//   TX_P_DATA       response byte, qualified by TX_D_VLD
//   cmd_err         one-cycle error pulse
// All outputs are registered.
// -----------------------------------------------------------------------------
module sys_ctrl_burst #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_BYTES = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [DATA_WIDTH-1:0]               RX_P_DATA,
    input  logic                                RX_ENABLE,
    input  logic                                FIFO_FULL,
    input  logic [DATA_WIDTH-1:0]               Rd_Data,
    input  logic                                Rd_Data_Valid,
    input  logic [ALU_OUT_BYTES*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                                ALU_Valid,
    output logic                                Wr_En,
    output logic                                Rd_En,
    output logic [ADDR_WIDTH-1:0]               Address,
    output logic [DATA_WIDTH-1:0]               Wr_Data,
    output logic                                ALU_EN,
    output logic [3:0]                          ALU_FUN,
    output logic                                CLK_EN,
    output logic                                clk_div_en,
    output logic [DATA_WIDTH-1:0]               TX_P_DATA,
    output logic                                TX_D_VLD,
    output logic                                cmd_err
);

    localparam int ALU_W = ALU_OUT_BYTES * DATA_WIDTH;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int TXC_W = $clog2(ALU_OUT_BYTES + 1);

    // Last count value before the idle-cycle counter reaches TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU    = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_NO = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] OP_BWR    = DATA_WIDTH'(8'hEE);
    localparam logic [DATA_WIDTH-1:0] OP_BRD    = DATA_WIDTH'(8'hEF);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] GET_ADDR = 4'd1;
    localparam logic [3:0] GET_CNT  = 4'd2;
    localparam logic [3:0] GET_DATA = 4'd3;
    localparam logic [3:0] GET_OPA  = 4'd4;
    localparam logic [3:0] GET_OPB  = 4'd5;
    localparam logic [3:0] GET_FUN  = 4'd6;
    localparam logic [3:0] RF_RD    = 4'd7;
    localparam logic [3:0] RF_WAIT  = 4'd8;
    localparam logic [3:0] ALU_RUN  = 4'd9;
    localparam logic [3:0] ALU_WAIT = 4'd10;
    localparam logic [3:0] TX_PUSH  = 4'd11;

    logic [3:0]            state;
    logic [DATA_WIDTH-1:0] op;       // opcode of the frame in progress
    logic [ADDR_WIDTH-1:0] addr;     // running RF address
    logic [DATA_WIDTH-1:0] cnt;      // elements left, including the current one
    logic [ALU_W-1:0]      tx_buf;   // response bytes, LSB byte goes out next
    logic [TXC_W-1:0]      tx_left;  // response bytes still to push
    logic [TO_W-1:0]       to_cnt;   // idle cycles since the last frame byte

    logic in_get;   // collecting frame bytes; timeout applies
    logic busy;     // executing a frame; incoming bytes are rejected

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        in_get = 1'b0;
        if (state inside {GET_ADDR, GET_CNT, GET_DATA, GET_OPA, GET_OPB, GET_FUN})
            in_get = 1'b1;
        busy = !in_get && (state != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side reads the value from before this clock edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            op         <= '0;
            addr       <= '0;
            cnt        <= '0;
            tx_buf     <= '0;
            tx_left    <= '0;
            to_cnt     <= '0;
            Wr_En      <= 1'b0;
            Rd_En      <= 1'b0;
            Address    <= '0;
            Wr_Data    <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            CLK_EN     <= 1'b0;
            clk_div_en <= 1'b0;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            clk_div_en <= 1'b1;
            Wr_En      <= 1'b0;
            Rd_En      <= 1'b0;
            ALU_EN     <= 1'b0;
            TX_D_VLD   <= 1'b0;
            cmd_err    <= 1'b0;

            if (RX_ENABLE || !in_get)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_W'(1);

            case (state)
                IDLE: begin
                    if (RX_ENABLE) begin
                        op <= RX_P_DATA;
                        case (RX_P_DATA)
                            OP_WR, OP_RD, OP_BWR, OP_BRD: state <= GET_ADDR;
                            OP_ALU:                       state <= GET_OPA;
                            OP_ALU_NO:                    state <= GET_FUN;
                            default:                      cmd_err <= 1'b1;
                        endcase
                    end
                end

                GET_ADDR: begin
                    if (RX_ENABLE) begin
                        addr <= RX_P_DATA[ADDR_WIDTH-1:0];
                        // Single accesses reuse the burst path with N = 1.
                        cnt  <= DATA_WIDTH'(1);
                        if (op == OP_WR)
                            state <= GET_DATA;
                        else if (op == OP_RD)
                            state <= RF_RD;
                        else
                            state <= GET_CNT;
                    end
                end

                GET_CNT: begin
                    if (RX_ENABLE) begin
                        if (RX_P_DATA == '0) begin
                            cmd_err <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cnt   <= RX_P_DATA;
                            state <= (op == OP_BWR) ? GET_DATA : RF_RD;
                        end
                    end
                end

                GET_DATA: begin
                    if (RX_ENABLE) begin
                        Wr_En   <= 1'b1;
                        Address <= addr;
                        Wr_Data <= RX_P_DATA;
                        addr    <= addr + ADDR_WIDTH'(1);
                        cnt     <= cnt - DATA_WIDTH'(1);
                        if (cnt == DATA_WIDTH'(1))
                            state <= IDLE;
                    end
                end

                GET_OPA: begin
                    if (RX_ENABLE) begin
                        Wr_En   <= 1'b1;
                        Address <= ADDR_WIDTH'(0);
                        Wr_Data <= RX_P_DATA;
                        state   <= GET_OPB;
                    end
                end

                GET_OPB: begin
                    if (RX_ENABLE) begin
                        Wr_En   <= 1'b1;
                        Address <= ADDR_WIDTH'(1);
                        Wr_Data <= RX_P_DATA;
                        state   <= GET_FUN;
                    end
                end

                GET_FUN: begin
                    if (RX_ENABLE) begin
                        ALU_FUN <= RX_P_DATA[3:0];
                        state   <= ALU_RUN;
                    end
                end

                RF_RD: begin
                    Rd_En   <= 1'b1;
                    Address <= addr;
                    state   <= RF_WAIT;
                end

                RF_WAIT: begin
                    if (Rd_Data_Valid) begin
                        tx_buf  <= ALU_W'(Rd_Data);
                        tx_left <= TXC_W'(1);
                        state   <= TX_PUSH;
                    end
                end

                ALU_RUN: begin
                    ALU_EN <= 1'b1;
                    CLK_EN <= 1'b1;
                    state  <= ALU_WAIT;
                end

                ALU_WAIT: begin
                    if (ALU_Valid) begin
                        CLK_EN  <= 1'b0;
                        tx_buf  <= ALU_OUT;
                        tx_left <= TXC_W'(ALU_OUT_BYTES);
                        state   <= TX_PUSH;
                    end
                end

                TX_PUSH: begin
                    // The byte stays at the bottom of tx_buf until the FIFO
                    // has room, so a full FIFO neither loses nor repeats it.
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= tx_buf[DATA_WIDTH-1:0];
                        tx_buf    <= tx_buf >> DATA_WIDTH;
                        tx_left   <= tx_left - TXC_W'(1);
                        if (tx_left == TXC_W'(1)) begin
                            if (op == OP_BRD && cnt != DATA_WIDTH'(1)) begin
                                cnt   <= cnt - DATA_WIDTH'(1);
                                addr  <= addr + ADDR_WIDTH'(1);
                                state <= RF_RD;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase

            // A byte arriving while a frame executes is dropped; the
            // operation itself carries on.
            if (RX_ENABLE && busy)
                cmd_err <= 1'b1;

            // Stalled frame: drop it. RF writes already issued stay done.
            if (in_get && !RX_ENABLE && to_cnt == TO_LAST) begin
                cmd_err <= 1'b1;
                state   <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// -----------------------------------------------------------------------------
// tb_sys_ctrl_burst
//
// Directed frames with hand-computed responses. The stimulus process pushes
// the expected RF writes, ALU starts, TX bytes and error pulses into queues;
// a monitor process pops and compares whenever the DUT strobes an output.
// Small RF and ALU models answer read and start strobes.
// -----------------------------------------------------------------------------
module tb_sys_ctrl_burst;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int AB = 2;
    localparam int TO = 255;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] RX_P_DATA;
    logic          RX_ENABLE;
    logic          FIFO_FULL;
    logic [DW-1:0] Rd_Data = '0;
    logic          Rd_Data_Valid = 1'b0;
    logic [AB*DW-1:0] ALU_OUT;
    logic          ALU_Valid = 1'b0;
    logic          Wr_En;
    logic          Rd_En;
    logic [AW-1:0] Address;
    logic [DW-1:0] Wr_Data;
    logic          ALU_EN;
    logic [3:0]    ALU_FUN;
    logic          CLK_EN;
    logic          clk_div_en;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_D_VLD;
    logic          cmd_err;

    sys_ctrl_burst #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .ALU_OUT_BYTES(AB),
        .TIMEOUT      (TO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_ENABLE    (RX_ENABLE),
        .FIFO_FULL    (FIFO_FULL),
        .Rd_Data      (Rd_Data),
        .Rd_Data_Valid(Rd_Data_Valid),
        .ALU_OUT      (ALU_OUT),
        .ALU_Valid    (ALU_Valid),
        .Wr_En        (Wr_En),
        .Rd_En        (Rd_En),
        .Address      (Address),
        .Wr_Data      (Wr_Data),
        .ALU_EN       (ALU_EN),
        .ALU_FUN      (ALU_FUN),
        .CLK_EN       (CLK_EN),
        .clk_div_en   (clk_div_en),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .cmd_err      (cmd_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];
    logic [3:0] alu_q[$];
    int         err_pushed = 0;
    int         err_seen   = 0;
    int         n_vec      = 0;
    int         n_fail     = 0;
    logic       full_q     = 1'b0;
    logic       alu_pend   = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // RF model: answers a read strobe in the same cycle with A0 | address.
    always @(posedge CLK) begin
        #1;
        Rd_Data_Valid = Rd_En;
        Rd_Data       = {4'hA, Address};
    end

    // ALU model: result valid one cycle after the start strobe.
    always @(posedge CLK) begin
        #1;
        ALU_Valid = alu_pend;
        alu_pend  = ALU_EN;
    end

    // FIFO_FULL as the DUT saw it at the last edge.
    always @(posedge CLK) full_q <= FIFO_FULL;

    // Monitor / scoreboard.
    initial begin : monitor
        wr_t w;
        forever begin
            @(negedge CLK);
            if (RST) begin
                if (Wr_En) begin
                    check("wr_expected", 32'(wr_q.size() > 0), 1);
                    if (wr_q.size() > 0) begin
                        w = wr_q.pop_front();
                        check("wr_addr", 32'(Address), 32'(w.addr));
                        check("wr_data", 32'(Wr_Data), 32'(w.data));
                    end
                end
                if (TX_D_VLD) begin
                    check("tx_expected", 32'(tx_q.size() > 0), 1);
                    check("tx_while_full", 32'(full_q), 0);
                    if (tx_q.size() > 0)
                        check("tx_byte", 32'(TX_P_DATA), 32'(tx_q.pop_front()));
                end
                if (ALU_EN) begin
                    check("alu_expected", 32'(alu_q.size() > 0), 1);
                    check("alu_clk_en", 32'(CLK_EN), 1);
                    if (alu_q.size() > 0)
                        check("alu_fun", 32'(ALU_FUN), 32'(alu_q.pop_front()));
                end
                if (cmd_err) begin
                    check("err_expected", 32'(err_seen < err_pushed), 1);
                    err_seen++;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_ENABLE = 1'b1;
        @(posedge CLK);
        #1;
        RX_ENABLE = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
    endtask

    // Waits (bounded) until every expectation is consumed, idles a few more
    // cycles to catch stray strobes, then checks nothing is left over.
    task automatic drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (wr_q.size() == 0 && tx_q.size() == 0 && alu_q.size() == 0 &&
                err_seen == err_pushed)
                break;
            @(posedge CLK);
            #1;
        end
        repeat (5) @(posedge CLK);
        #1;
        check({tag, " wr_left"},  32'(wr_q.size()),  0);
        check({tag, " tx_left"},  32'(tx_q.size()),  0);
        check({tag, " alu_left"}, 32'(alu_q.size()), 0);
        check({tag, " err_left"}, 32'(err_pushed - err_seen), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int  n;
        logic found;

        RST       = 1'b0;
        RX_ENABLE = 1'b0;
        RX_P_DATA = '0;
        FIFO_FULL = 1'b0;
        ALU_OUT   = '0;

        // Reset state.
        #12;
        check("reset_outputs",
              {1'b0, Wr_En, Rd_En, ALU_EN, CLK_EN, clk_div_en, TX_D_VLD, cmd_err,
               Address, Wr_Data, ALU_FUN, TX_P_DATA}, 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("clk_div_en_after_reset", 32'(clk_div_en), 1);

        // 1: single write.
        push_wr(4'd5, 8'h3C);
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        drain("t1");

        // 2: ALU with operands, then ALU without operands.
        push_wr(4'd0, 8'h07);
        push_wr(4'd1, 8'h03);
        alu_q.push_back(4'd0);
        tx_q.push_back(8'h0A);
        tx_q.push_back(8'h00);
        ALU_OUT = 16'h000A;
        send_byte(8'hCC); send_byte(8'h07); send_byte(8'h03); send_byte(8'h00);
        drain("t2a");

        alu_q.push_back(4'd5);
        tx_q.push_back(8'h34);
        tx_q.push_back(8'h12);
        ALU_OUT = 16'h1234;
        send_byte(8'hDD); send_byte(8'h05);
        drain("t2b");

        // 3: burst write wrapping past the top address.
        push_wr(4'd14, 8'h11);
        push_wr(4'd15, 8'h22);
        push_wr(4'd0,  8'h33);
        send_byte(8'hEE); send_byte(8'h0E); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        drain("t3");

        // 4: burst read with FIFO backpressure after the first byte, plus a
        // byte arriving mid-operation that must be rejected.
        tx_q.push_back(8'hA2);
        tx_q.push_back(8'hA3);
        send_byte(8'hEF); send_byte(8'h02); send_byte(8'h02);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (TX_D_VLD) begin
                found = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        check("t4 first_tx_seen", 32'(found), 1);
        FIFO_FULL = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        err_pushed++;
        send_byte(8'h55);
        repeat (13) @(posedge CLK);
        #1;
        check("t4 tx_held_while_full", 32'(tx_q.size()), 1);
        FIFO_FULL = 1'b0;
        drain("t4");

        // 5: inter-byte timeout, then a fresh frame.
        err_pushed++;
        send_byte(8'hAA); send_byte(8'h05);
        n = 1;
        while (!cmd_err && n < 400) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("t5 timeout_cycles", 32'(n), TO);
        drain("t5a");
        push_wr(4'd1, 8'hFF);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
        drain("t5b");

        // 6: unknown opcode, zero-length burst, reset mid-burst.
        err_pushed++;
        send_byte(8'h42);
        drain("t6a");
        err_pushed++;
        send_byte(8'hEE); send_byte(8'h03); send_byte(8'h00);
        drain("t6b");
        push_wr(4'd4, 8'h11);
        send_byte(8'hEE); send_byte(8'h04); send_byte(8'h03); send_byte(8'h11);
        drain("t6c");
        RST = 1'b0;
        #1;
        check("t6 outputs_in_reset",
              {1'b0, Wr_En, Rd_En, ALU_EN, CLK_EN, clk_div_en, TX_D_VLD, cmd_err,
               Address, Wr_Data, ALU_FUN, TX_P_DATA}, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("t6 clk_div_en_after_reset", 32'(clk_div_en), 1);
        push_wr(4'd3, 8'h5A);
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h5A);
        drain("t6d");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_burst.md
Name: sys_ctrl_burst

Overview:
Parametrised next-generation system controller for the REF_CLK domain.
- Decodes command frames arriving as synchronised UART RX bytes.
- Drives the register file and ALU, and pushes response bytes into the TX async FIFO.
- Adds three things the existing controller lacks: burst RF write/read with address auto-increment, FIFO-full backpressure, and an inter-byte timeout with error reporting.

Parameters:
DATA_WIDTH, 8, width of RX/TX bytes and RF data
ADDR_WIDTH, 4, RF address width (depth 2^ADDR_WIDTH)
ALU_OUT_BYTES, 2, number of DATA_WIDTH bytes sent per ALU result (ALU_OUT width = ALU_OUT_BYTES*DATA_WIDTH)
TIMEOUT, 255, max idle cycles between frame bytes; counter width $clog2(TIMEOUT+1)

Ports:
CLK  in  1  REF_CLK-domain clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  synchronised RX byte
RX_ENABLE  in  1  one-cycle RX byte strobe
FIFO_FULL  in  1  TX FIFO full
Rd_Data  in  DATA_WIDTH  RF read data
Rd_Data_Valid  in  1  RF read data valid
ALU_OUT  in  ALU_OUT_BYTES*DATA_WIDTH  ALU result
ALU_Valid  in  1  ALU result valid
Wr_En  out  1  RF write strobe
Rd_En  out  1  RF read strobe
Address  out  ADDR_WIDTH  RF address
Wr_Data  out  DATA_WIDTH  RF write data
ALU_EN  out  1  ALU start strobe
ALU_FUN  out  4  ALU function
CLK_EN  out  1  ALU clock-gate enable
clk_div_en  out  1  UART clock-divider enable
TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  out  1  TX FIFO write strobe
cmd_err  out  1  one-cycle error pulse

Behaviour:
Reset:
- All outputs are registered and reset to 0; FSM goes to IDLE.
- clk_div_en rises to 1 on the first clock after RST deasserts and stays 1.

Frame formats (address byte uses its low ADDR_WIDTH bits):
- 0xAA RF write: addr, data.
- 0xBB RF read: addr.
- 0xCC ALU with operands: A, B, FUN.
- 0xDD ALU without operands: FUN.
- 0xEE burst write: addr, N, then N data bytes.
- 0xEF burst read: addr, N.

FSM states: IDLE, GET_ADDR, GET_CNT, GET_DATA, GET_OPA, GET_OPB, GET_FUN, RF_RD, RF_WAIT, ALU_RUN, ALU_WAIT, TX_PUSH.

RF writes:
- Wr_En pulses for one cycle, the cycle after the data byte's RX_ENABLE.
- Address and Wr_Data are valid in that same cycle.
- 0xCC writes A to address 0 and B to address 1, each as it arrives.

RF reads:
- Rd_En pulses one cycle, then the FSM waits in RF_WAIT for Rd_Data_Valid.
- On Rd_Data_Valid the byte is latched and the FSM enters TX_PUSH.

ALU:
- ALU_EN pulses one cycle with ALU_FUN held; CLK_EN goes high in the same cycle.
- CLK_EN stays high until the cycle ALU_Valid is seen.
- ALU_OUT is latched, then ALU_OUT_BYTES bytes are pushed LSB byte first.

TX_PUSH:
- TX_D_VLD is asserted for one cycle per byte, only when FIFO_FULL=0.
- While FIFO_FULL=1, TX_D_VLD stays low and the byte is held; no byte is lost or duplicated.

Bursts:
- Address increments by 1 after each element and wraps modulo 2^ADDR_WIDTH.
- Burst read interleaves RF_RD, RF_WAIT and TX_PUSH per element.
- N=0 causes a cmd_err pulse and return to IDLE.

Timeout:
- The counter clears on every RX_ENABLE.
- It counts only in GET_* states. On reaching TIMEOUT: cmd_err pulses, the partial frame is dropped, and the FSM returns to IDLE. Any RF writes already issued remain.

Unknown opcode in IDLE: cmd_err pulses; FSM stays in IDLE.

RX_ENABLE while in RF_RD, RF_WAIT, ALU_RUN, ALU_WAIT or TX_PUSH: the byte is dropped and cmd_err pulses. The operation in progress continues unaffected.

Reset mid-operation: takes effect immediately. All strobes go to 0, the FSM goes to IDLE, and latched bytes are discarded.

Test Plan:
1. Bytes AA,05,3C → one Wr_En pulse with Address=5, Wr_Data=0x3C; no TX_D_VLD.
2. Bytes CC,07,03,00 with ALU_OUT=0x000A one cycle after ALU_EN → Wr_En at addr 0 (data 7) and addr 1 (data 3); ALU_EN with ALU_FUN=0; TX bytes 0x0A then 0x00.
3. Bytes EE,0E,03,11,22,33 → writes 0x11@14, 0x22@15, 0x33@0 (wrap).
4. Bytes EF,02,02 with FIFO_FULL=1 for 20 cycles after the first read → exactly two TX_D_VLD pulses, in order, with the second only after FIFO_FULL falls.
5. Bytes AA,05 then no more bytes for 256 cycles → single cmd_err at cycle TIMEOUT; no Wr_En; next AA,01,FF frame is accepted.
6. Opcode 0x42 → cmd_err; a burst with N=0 → cmd_err; RST asserted mid-burst → all outputs 0 and state IDLE.
